// File: rtl/servant_periph_pkg.sv
// Shared constants and helpers for the servant peripheral: register word indices
// and the byte-lane write merge used by every byte-enabled register.
package servant_periph_pkg;

  localparam logic [3:0] REG_GPIO_OUT   = 4'd0;
  localparam logic [3:0] REG_GPIO_IN    = 4'd1;
  localparam logic [3:0] REG_MTIME      = 4'd2;
  localparam logic [3:0] REG_IRQ_STATUS = 4'd3;
  localparam logic [3:0] REG_IRQ_ENABLE = 4'd4;
  localparam logic [3:0] REG_PRESCALE   = 4'd5;
  localparam logic [3:0] REG_CMP_BASE   = 4'd8;

  localparam int unsigned NUM_CH_MAX = 8;

  function automatic logic [31:0] be_merge(input logic [31:0] cur, input logic [31:0] wdat,
                                           input logic [3:0] sel);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/servant_periph_if.sv
// Wishbone slave bus bundle for the servant peripheral (classic cycle, one-cycle ack).
interface servant_periph_if;
  logic [3:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, output dat, output sel, output we, output cyc,
                  input rdt, input ack);
  modport slave  (input adr, input dat, input sel, input we, input cyc,
                  output rdt, output ack);
endinterface

// File: rtl/servant_periph_chan.sv
// One compare channel: byte-writable compare value and a sticky match flag.
module servant_periph_chan import servant_periph_pkg::*; #(
  parameter int unsigned TIMER_W = 32,
  parameter bit          RST_CNT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [TIMER_W-1:0] mtime,
  input  logic               cmp_we,
  input  logic [31:0]        cmp_wdat,
  input  logic [3:0]         cmp_sel,
  input  logic               w1c,
  output logic [TIMER_W-1:0] cmp,
  output logic               status
);

  logic [TIMER_W-1:0] cmp_q, cmp_d;
  logic               status_q, status_d;

  always_comb begin
    cmp_d    = cmp_q;
    status_d = status_q;
    if (cmp_we) cmp_d = TIMER_W'(be_merge(32'(cmp_q), cmp_wdat, cmp_sel));
    if (w1c) status_d = 1'b0;
    // Compare against the old compare value so a fresh write cannot self-trigger;
    // a match overrides a simultaneous clear.
    if (tick && (mtime == cmp_q)) status_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) status_q <= 1'b0;
    else     status_q <= status_d;
  end

  always_ff @(posedge clk) begin
    if (RST_CNT && rst) cmp_q <= '1;
    else                cmp_q <= cmp_d;
  end

  assign cmp    = cmp_q;
  assign status = status_q;

endmodule

// File: rtl/servant_periph.sv
// Servant GPIO + timer peripheral: GPIO out/in, free-running counter, NUM_CH compare
// channels with masked irq. Define SERVANT_PERIPH_PRESCALE_EN to add the tick prescaler.
module servant_periph import servant_periph_pkg::*; #(
  parameter int unsigned GPIO_W         = 8,
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned TIMER_W        = 32,
  parameter string       RESET_STRATEGY = "MINI"
) (
  input  logic                i_clk,
  input  logic                i_rst,
  servant_periph_if.slave     wb,
  input  logic [GPIO_W-1:0]   i_gpio,
  output logic [GPIO_W-1:0]   o_gpio,
  output logic                o_irq
);

  localparam bit RstCnt = (RESET_STRATEGY != "NONE");

  logic               ack_q;
  logic [31:0]        rdt_q, rd_data;
  logic [GPIO_W-1:0]  gpio_out_q, gpio_out_d, sync1_q, sync2_q;
  logic [NUM_CH-1:0]  enable_q, enable_d, status;
  logic [TIMER_W-1:0] mtime_q, mtime_d;
  logic [TIMER_W-1:0] cmp [NUM_CH];
  logic               req, wr, tick;

  assign req = wb.cyc & ~ack_q;
  assign wr  = req & wb.we;

`ifdef SERVANT_PERIPH_PRESCALE_EN
  logic [15:0] prescale_q, prescale_d, div_q, div_d;

  assign tick = (div_q == prescale_q);

  always_comb begin
    prescale_d = prescale_q;
    div_d      = tick ? 16'd0 : div_q + 16'd1;
    if (wr && wb.adr == REG_PRESCALE) begin
      prescale_d = 16'(be_merge(32'(prescale_q), wb.dat, wb.sel));
      div_d      = 16'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prescale_q <= 16'd0;
      div_q      <= 16'd0;
    end else begin
      prescale_q <= prescale_d;
      div_q      <= div_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    gpio_out_d = gpio_out_q;
    enable_d   = enable_q;
    mtime_d    = tick ? mtime_q + 1'b1 : mtime_q;
    if (wr && wb.adr == REG_GPIO_OUT) begin
      gpio_out_d = GPIO_W'(be_merge(32'(gpio_out_q), wb.dat, wb.sel));
    end
    if (wr && wb.adr == REG_IRQ_ENABLE) begin
      enable_d = NUM_CH'(be_merge(32'(enable_q), wb.dat, wb.sel));
    end
    if (wr && wb.adr == REG_MTIME) begin
      mtime_d = TIMER_W'(be_merge(32'(mtime_q), wb.dat, wb.sel));
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (wb.adr)
      REG_GPIO_OUT:   rd_data = 32'(gpio_out_q);
      REG_GPIO_IN:    rd_data = 32'(sync2_q);
      REG_MTIME:      rd_data = 32'(mtime_q);
      REG_IRQ_STATUS: rd_data = 32'(status);
      REG_IRQ_ENABLE: rd_data = 32'(enable_q);
`ifdef SERVANT_PERIPH_PRESCALE_EN
      REG_PRESCALE:   rd_data = 32'(prescale_q);
`endif
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (wb.adr == REG_CMP_BASE + 4'(k)) rd_data = 32'(cmp[k]);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q      <= 1'b0;
      rdt_q      <= 32'd0;
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      enable_q   <= '0;
    end else begin
      ack_q      <= req;
      rdt_q      <= req ? rd_data : 32'd0;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= i_gpio;
      sync2_q    <= sync1_q;
      enable_q   <= enable_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (RstCnt && i_rst) mtime_q <= '0;
    else                 mtime_q <= mtime_d;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    servant_periph_chan #(
      .TIMER_W (TIMER_W),
      .RST_CNT (RstCnt)
    ) u_chan (
      .clk      (i_clk),
      .rst      (i_rst),
      .tick     (tick),
      .mtime    (mtime_q),
      .cmp_we   (wr && (wb.adr == REG_CMP_BASE + 4'(k))),
      .cmp_wdat (wb.dat),
      .cmp_sel  (wb.sel),
      .w1c      (wr && (wb.adr == REG_IRQ_STATUS) && wb.sel[0] && wb.dat[k]),
      .cmp      (cmp[k]),
      .status   (status[k])
    );
  end

  assign wb.ack = ack_q;
  assign wb.rdt = rdt_q;
  assign o_gpio = gpio_out_q;
  assign o_irq  = |(status & enable_q);

endmodule

// File: tb/tb_servant_periph.sv
// Scoreboard bench for servant_periph (GPIO_W=8, NUM_CH=2, TIMER_W=8).
module tb_servant_periph;

  localparam int unsigned GPIO_W  = 8;
  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned TIMER_W = 8;

  typedef struct {
    bit          chk;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [GPIO_W-1:0] gpio_in = '0;
  logic [GPIO_W-1:0] gpio_out;
  logic              irq;
  bit                mon_en = 1'b0;
  int                n_checks = 0;
  int                n_errors = 0;
  int                cycle_cnt = 0;
  exp_t              sb_q[$];
  exp_t              mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  servant_periph_if wb();

  servant_periph #(
    .GPIO_W         (GPIO_W),
    .NUM_CH         (NUM_CH),
    .TIMER_W        (TIMER_W),
    .RESET_STRATEGY ("MINI")
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .wb     (wb),
    .i_gpio (gpio_in),
    .o_gpio (gpio_out),
    .o_irq  (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every ack pops one scoreboard entry; rdt must be zero whenever ack is low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb.ack) begin
        if (sb_q.size() == 0) begin
          check("spurious_ack", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.chk) check(mon_e.tag, wb.rdt, mon_e.val);
        end
      end else begin
        check("rdt_idle", wb.rdt, 32'd0);
      end
    end
  end

  task automatic wb_xfer(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input bit chk, input logic [31:0] exp,
                         input string tag);
    exp_t ent;
    int   n;
    ent.chk = chk;
    ent.val = exp;
    ent.tag = tag;
    sb_q.push_back(ent);
    @(posedge clk); #1;
    wb.adr = adr;
    wb.dat = dat;
    wb.sel = sel;
    wb.we  = we;
    wb.cyc = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb.ack && n < 20);
    wb.cyc = 1'b0;
    wb.we  = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'd1);
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb_xfer(adr, dat, sel, 1'b1, 1'b0, 32'd0, "wr");
  endtask

  task automatic wb_read(input logic [3:0] adr, input logic [31:0] exp, input string tag);
    wb_xfer(adr, 32'd0, 4'hf, 1'b0, 1'b1, exp, tag);
  endtask

  task automatic wait_irq(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!irq && n < limit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int t1;
    int t2;
    wb.adr = '0; wb.dat = '0; wb.sel = '0; wb.we = 1'b0; wb.cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state; counter has advanced once by the time the first read samples it.
    wb_read(REG_MTIME_IDX(), 32'h1, "rst_mtime");
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_gpio", 32'(gpio_out), 32'd0);
    wb_read(4'd0, 32'h0, "rst_gpio_out");
    wb_read(4'd1, 32'h0, "rst_gpio_in");
    wb_read(4'd3, 32'h0, "rst_status");
    wb_read(4'd4, 32'h0, "rst_enable");
    wb_read(4'd8, 32'hff, "rst_cmp0");
    wb_read(4'd9, 32'hff, "rst_cmp1");
    wb_read(4'd5, 32'h0, "rst_idx5");
    wb_read(4'd12, 32'h0, "rst_idx12");
    wb_write(4'd2, 32'h40, 4'hf);
    wb_read(4'd2, 32'h41, "mtime_wr");

    // GPIO byte lanes and input synchroniser.
    wb_write(4'd0, 32'ha5, 4'b0001);
    wb_write(4'd0, 32'hff, 4'b0010);
    wb_read(4'd0, 32'ha5, "gpio_out_be");
    check("o_gpio", 32'(gpio_out), 32'ha5);
    gpio_in = 8'h3c;
    repeat (3) @(posedge clk);
    wb_read(4'd1, 32'h3c, "gpio_in");
    wb_write(4'd4, 32'h3, 4'hf);
    wb_read(4'd4, 32'h3, "enable_rw");
`ifndef SERVANT_PERIPH_PRESCALE_EN
    wb_write(4'd5, 32'h3, 4'hf);
    wb_read(4'd5, 32'h0, "idx5_unmapped");
`endif

    // Compare match, W1C, and re-trigger after counter wrap.
    wb_write(4'd3, 32'hff, 4'b0001);
    wb_write(4'd8, 32'd20, 4'hf);
    wb_write(4'd4, 32'h1, 4'hf);
    wb_write(4'd2, 32'h0, 4'hf);
    wait_irq(40, n);
    check("irq_rise", 32'(n), 32'd21);
    t1 = cycle_cnt;
    wb_read(4'd3, 32'h1, "status_set");
    wb_write(4'd3, 32'h1, 4'b0001);
    check("irq_clr", 32'(irq), 32'd0);
    wait_irq(400, n);
    t2 = cycle_cnt;
    check("wrap_period", 32'(t2 - t1), 32'd256);
    wb_read(4'd3, 32'h3, "status_wrap");

    // Set beats a same-cycle clear; clears only via lane 0.
    wb_write(4'd3, 32'h3, 4'b0001);
    wb_write(4'd9, 32'd100, 4'hf);
    wb_write(4'd2, 32'd99, 4'hf);
    wb_write(4'd3, 32'h2, 4'b0001);
    wb_read(4'd3, 32'h2, "set_wins");
    wb_write(4'd3, 32'h2, 4'b0010);
    wb_read(4'd3, 32'h2, "w1c_lane1");
    wb_write(4'd3, 32'h2, 4'b0001);
    wb_read(4'd3, 32'h0, "w1c_bit1");
    check("irq_ch1_masked", 32'(irq), 32'd0);

    // Reset during a write: no ack while held, ack one cycle after release.
    begin
      exp_t ent;
      ent.chk = 1'b0;
      ent.val = 32'd0;
      ent.tag = "rst_wr";
      sb_q.push_back(ent);
      @(posedge clk); #1;
      wb.adr = 4'd0; wb.dat = 32'h11; wb.sel = 4'hf; wb.we = 1'b1; wb.cyc = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_ack0", 32'(wb.ack), 32'd0);
      @(posedge clk); #1;
      check("rst_ack1", 32'(wb.ack), 32'd0);
      check("rst_gpio_mid", 32'(gpio_out), 32'd0);
      rst = 1'b0;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!wb.ack && n < 20);
      wb.cyc = 1'b0;
      wb.we  = 1'b0;
      check("post_rst_ack", 32'(n), 32'd1);
      check("post_rst_gpio", 32'(gpio_out), 32'h11);
    end
    wb_read(4'd4, 32'h0, "post_rst_enable");
    wb_read(4'd3, 32'h0, "post_rst_status");

`ifdef SERVANT_PERIPH_PRESCALE_EN
    // Prescale 3: one tick per four cycles.
    wb_write(4'd8, 32'd5, 4'hf);
    wb_write(4'd4, 32'h1, 4'hf);
    wb_write(4'd5, 32'd3, 4'hf);
    wb_write(4'd2, 32'd0, 4'hf);
    wb_write(4'd3, 32'hff, 4'b0001);
    wait_irq(60, n);
    check("presc_irq", 32'(n), 32'd20);
    wb_read(4'd2, 32'd6, "presc_mtime");
    wb_read(4'd5, 32'd3, "presc_rd");
`endif

    repeat (2) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  function automatic logic [3:0] REG_MTIME_IDX();
    return 4'd2;
  endfunction

endmodule

// File: doc/servant_periph.md
Name: servant_periph

Overview:
- Parametrised successor to the single-bit GPIO / single-compare timer pair on the servant external Wishbone bus.
- One Wishbone slave with:
  - GPIO_W-bit output and input ports
  - a free-running TIMER_W-bit counter
  - NUM_CH independent compare channels, each with a sticky interrupt flag
  - a masked, combined interrupt output
- Sits behind the external-bus address mux; o_irq feeds the CPU timer interrupt input.

Parameters:
- GPIO_W, 8, width of o_gpio / i_gpio (1..32)
- NUM_CH, 2, number of compare channels (1..8)
- TIMER_W, 32, counter and compare width (8..32)
- RESET_STRATEGY, "MINI", "NONE" removes reset from the counter and compare registers only; control/status registers are always reset

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_wb_adr  in  4  word address (byte address bits [5:2])
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte enables
- i_wb_we  in  1  write strobe
- i_wb_cyc  in  1  cycle/strobe, held until ack
- o_wb_rdt  out  32  read data, valid with ack
- o_wb_ack  out  1  one-cycle acknowledge
- i_gpio  in  GPIO_W  asynchronous inputs
- o_gpio  out  GPIO_W  registered outputs
- o_irq  out  1  OR of (status & enable)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high. All state changes on the rising edge of i_clk.
- Register map (word index):
  - 0 GPIO_OUT (RW)
  - 1 GPIO_IN (RO)
  - 2 MTIME (RW)
  - 3 IRQ_STATUS (W1C, bits [NUM_CH-1:0])
  - 4 IRQ_ENABLE (RW)
  - 5 PRESCALE (optional feature)
  - 8..8+NUM_CH-1 CMP[k] (RW)
  - All other indices: read 0, writes ignored, still acked.
- Handshake:
  - o_wb_ack <= i_wb_cyc & ~o_wb_ack, so latency is 1 cycle and ack never asserts two cycles in a row.
  - Writes take effect on the edge that raises ack.
  - o_wb_rdt is registered on that same edge and is 0 when ack is low.
- Byte enables:
  - Honoured on GPIO_OUT, MTIME, IRQ_ENABLE, PRESCALE and CMP.
  - IRQ_STATUS clears use lane 0 only.
  - Bits above the field width read 0.
- GPIO_IN: two-flop synchroniser; a read returns the value 2–3 cycles stale.
- Counter:
  - MTIME increments by 1 every tick (every cycle without the optional feature) and wraps from 2^TIMER_W-1 to 0 silently.
  - A write to MTIME overrides the increment in that cycle.
- Match:
  - STATUS[k] is set on the edge where MTIME (pre-increment value) equals CMP[k] and a tick occurs.
  - STATUS is sticky until cleared by writing 1.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
  - Writing CMP[k] equal to the current MTIME does not set the flag until the counter next reaches that value.
- Interrupt: o_irq = |(STATUS & ENABLE), driven from flops with no combinational path from the bus.
- Reset values:
  - GPIO_OUT=0, o_gpio=0, MTIME=0, CMP[k]=all-ones
  - STATUS=0, ENABLE=0, o_irq=0
  - o_wb_ack=0, o_wb_rdt=0, synchroniser=0
- Reset mid-transaction: a pending ack is dropped. If i_wb_cyc is still high after reset releases, ack follows one cycle later.

Optional Feature:
- Macro: SERVANT_PERIPH_PRESCALE_EN.
- Defined:
  - Adds the 16-bit PRESCALE register (index 5, reset 0) and an internal divider counter.
  - The tick fires when the divider equals PRESCALE; the divider then returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - A write to PRESCALE resets the divider to 0.
- Undefined:
  - Tick is constant 1.
  - Index 5 behaves as unmapped.

Decomposition:
- Package servant_periph_pkg holds:
  - register index constants (REG_GPIO_OUT … REG_CMP_BASE)
  - NUM_CH_MAX=8
  - a byte-enable write-merge function
- Sub-module servant_periph_chan, instantiated NUM_CH times:
  - inputs: clk, rst, tick, mtime, CMP write strobe/data/sel, W1C bit
  - outputs: cmp value, status bit

Test Plan:
1. Reset, read all registers -> GPIO_OUT=0, MTIME≈0 (advancing), STATUS=0, CMP0=0xFFFFFFFF, o_irq=0; each read acked exactly 1 cycle after cyc.
2. Write GPIO_OUT=0xA5 with sel=4'b0001, then 0xFF with sel=4'b0010 -> o_gpio=0xA5; drive i_gpio=0x3C -> GPIO_IN reads 0x3C within 3 cycles.
3. CMP0=20, ENABLE=1, MTIME=0 -> STATUS[0] and o_irq rise after the tick at MTIME=20; write STATUS=1 -> o_irq=0; flag stays clear until wrap (~2^32 cycles; use TIMER_W=8, expect re-set after 256 ticks).
4. Time a W1C of STATUS[1] to land on the match cycle of CMP1 -> STATUS[1] remains 1.
5. Assert i_rst with cyc high, mid-write -> ack suppressed, register unchanged; after release, ack arrives 1 cycle later.
6. With SERVANT_PERIPH_PRESCALE_EN and PRESCALE=3 -> MTIME advances 1 per 4 cycles; CMP0=5 matches at cycle ~24 after PRESCALE write.
